host_reg_master: RTL and testbench
==================================

// Module: host_reg_master
// PURPOSE
// Host-side initiator for the register bus that register-bank instances respond to.
// Parses command frames from a host byte stream and performs single-word register writes and reads.
// Returns an ack byte or the read data on the outgoing byte stream.
// Sits between the host link (FX2/UART byte FIFOs) and every register instance in timetagger.
// PARAMETERS
// ADDR_WIDTH    16    register address width; sent as 2 bytes, LSB first
// DATA_WIDTH    32    register data width; sent as 4 bytes, LSB first
// READ_LATENCY  2     cycles from address valid to sampling reg_data_i (>=1)
// TIMEOUT       1024  idle cycles allowed between bytes of one frame before abort
// PORTS
// clk_i         in   1   single clock for all logic
// reset_i       in   1   synchronous, active-high reset
// rx_data_i     in   8   incoming host byte
// rx_valid_i    in   1   rx_data_i valid
// rx_ready_o    out  1   byte accepted when rx_valid_i && rx_ready_o
// tx_data_o     out  8   outgoing response byte
// tx_valid_o    out  1   tx_data_o valid
// tx_ready_i    in   1   byte consumed when tx_valid_o && tx_ready_i
// reg_addr_o    out  16  register bus address
// reg_data_o    out  32  write data driven onto the bus
// reg_data_oe_o out  1   reg_data_o drives the shared data bus when high
// reg_data_i    in   32  read data from the shared data bus
// reg_wr_o      out  1   one-cycle write strobe
// busy_o        out  1   high in every state except IDLE
// BEHAVIOUR
// - Frame: opcode, addr[7:0], addr[15:8], then for writes d[7:0]..d[31:24].
// - Opcode 0x01 is write; the response is 1 byte 0x01.
// - Opcode 0x02 is read; the response is 0x02 then 4 data bytes, LSB first.
// - Any other opcode: respond 0xEE, discard the byte, return to IDLE.
// - Reset values: state IDLE, rx_ready_o 0 while reset_i is high, tx_valid_o 0, reg_wr_o 0.
// - Reset values (cont.): reg_data_oe_o 0, reg_addr_o 0, reg_data_o 0, busy_o 0.
// - FSM states: IDLE, ADDR, WDATA, WRITE, RWAIT, RESP.
//   - IDLE: accept opcode -> ADDR (opcode 0x01/0x02) or RESP with 0xEE.
//   - ADDR: accept 2 bytes (byte counter) -> WDATA (write) or RWAIT (read).
//   - WDATA: accept 4 bytes -> WRITE.
//   - WRITE: exactly 1 cycle.
//     - reg_wr_o=1 and reg_data_oe_o=1, with reg_addr_o and reg_data_o stable.
//     - Next state RESP with ack 0x01.
//   - RWAIT: reg_addr_o driven, reg_data_oe_o=0, reg_wr_o=0.
//     - Wait READ_LATENCY cycles, then latch reg_data_i into a shift register.
//     - Next state RESP with 5 bytes.
//   - RESP: emit queued bytes in order; back to IDLE after the last handshake.
// - rx_ready_o is high only in IDLE, ADDR and WDATA; it is low in WRITE, RWAIT and RESP.
// - Assembly: bytes accepted one per handshake.
//   - Address and data are assembled by shifting in at the MSB end and shifting right.
//   - Byte k lands in bits [8k+7:8k].
// - Tx stability: while tx_valid_o && !tx_ready_i, tx_data_o and tx_valid_o hold.
// - Tx throughput: one byte per cycle is sustained when tx_ready_i stays high.
// - reg_addr_o updates only on entry to WRITE or RWAIT; it holds its last value otherwise.
// - reg_data_oe_o is high only in WRITE, so the shared bus is never driven during a read.
// - Latency (write): WRITE follows the cycle that accepts the last data byte.
// - Latency (write response): tx_valid_o rises on the cycle after WRITE.
// - Latency (read): the data sample happens READ_LATENCY cycles after RWAIT entry.
// - Latency (read response): tx_valid_o rises on the next cycle.
// - Timeout: in ADDR or WDATA, a free-running counter counts cycles with no accepted byte.
//   - Any accepted byte clears the counter.
//   - At TIMEOUT the frame is dropped and the FSM returns to IDLE.
//   - No bus cycle and no response are produced.
// - No partial writes: reg_wr_o fires only after all 7 bytes are received.
//   - A reset or timeout before that point produces no write.
// - Reset mid-operation: all outputs return to reset values on the next edge.
//   - A pending response is dropped.
//   - A write strobe never persists past the reset edge.
// - Back-to-back frames: the opcode of the next frame is accepted in IDLE.
//   - IDLE is reached on the cycle after the final tx handshake; no other gap is added.
// TESTING
// - Write: bytes 01 10 00 78 56 34 12 -> one reg_wr_o pulse, addr 0x0010, data 0x12345678, oe=1; tx 0x01.
// - Read, READ_LATENCY=2, reg_data_i=0xDEADBEEF at addr 0x0010: bytes 02 10 00 -> tx 02 EF BE AD DE; reg_wr_o stays 0.
// - Bad opcode: byte 0x7F -> tx 0xEE; no bus activity; the next frame 01... completes normally.
// - Timeout (TIMEOUT=16): 01 10 then 20 idle cycles -> return to IDLE, no write, no tx.
//   - A following 02 10 00 reads correctly.
// - Backpressure: tx_ready_i low for 5 cycles during a read response -> bytes held stable, none lost or duplicated.
// - Reset after the 5th write byte -> no reg_wr_o; all outputs at reset values; rx_ready_o=1 one cycle after reset_i falls.

Source files
------------

// File: rtl/host_reg_master.sv
// host_reg_master
//   Host-side initiator for the register bus. Parses command frames arriving
//   on a host byte stream, performs single-word register writes and reads,
//   and returns an ack byte or the read data on the outgoing byte stream.
//
//   Frame format (all multi-byte fields LSB first):
//     write : 0x01, addr[7:0], addr[15:8], d[7:0], d[15:8], d[23:16], d[31:24]
//             response 0x01
//     read  : 0x02, addr[7:0], addr[15:8]
//             response 0x02, d[7:0], d[15:8], d[23:16], d[31:24]
//     other : response 0xEE, opcode byte discarded
//
//   Handshake rule for both byte streams: a byte moves on a rising clock edge
//   where valid and ready are both high. The sender holds data and valid
//   stable until that edge; the receiver may raise or drop ready at any time.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   rx_data_i/valid_i/ready_o incoming host bytes
//   tx_data_o/valid_o/ready_i outgoing response bytes
//   reg_addr_o                register bus address (held between accesses)
//   reg_data_o, reg_data_oe_o write data and its bus-drive enable
//   reg_data_i                read data from the shared bus
//   reg_wr_o                  one-cycle write strobe
//   busy_o                    high whenever the FSM is not in IDLE
module host_reg_master #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_data_o,
  output logic                  reg_data_oe_o,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  output logic                  reg_wr_o,
  output logic                  busy_o
);

  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int RESP_W     = DATA_WIDTH + 8;
  localparam int CNT_W      = 4;
  localparam int TMO_W      = $clog2(TIMEOUT + 1);
  localparam int LAT_W      = $clog2(READ_LATENCY + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST    = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST    = CNT_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0] RD_RESP_LEN  = CNT_W'(DATA_BYTES + 1);
  localparam logic [CNT_W-1:0] ONE_BYTE     = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST     = LAT_W'(READ_LATENCY - 1);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WRITE = 3'd3,
    S_RWAIT = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  state_e                  state_q,    state_d;
  logic                    op_read_q,  op_read_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]        tmo_cnt_q,  tmo_cnt_d;
  logic [LAT_W-1:0]        lat_cnt_q,  lat_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_sr_q,  addr_sr_d;
  logic [DATA_WIDTH-1:0]   data_sr_q,  data_sr_d;
  logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]   reg_data_q, reg_data_d;
  logic [RESP_W-1:0]       tx_sr_q,    tx_sr_d;
  logic [CNT_W-1:0]        tx_left_q,  tx_left_d;

  logic rx_accept;
  logic tx_fire;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] data_next;

  // Outputs are pure functions of state so they can never glitch between
  // states; rx_ready_o is additionally forced low while reset is asserted.
  assign rx_ready_o    = !reset_i &&
                         (state_q == S_IDLE || state_q == S_ADDR || state_q == S_WDATA);
  assign rx_accept     = rx_valid_i && rx_ready_o;
  assign tx_valid_o    = (state_q == S_RESP);
  assign tx_data_o     = tx_sr_q[7:0];
  assign tx_fire       = tx_valid_o && tx_ready_i;
  assign reg_wr_o      = (state_q == S_WRITE);
  assign reg_data_oe_o = (state_q == S_WRITE);
  assign reg_addr_o    = reg_addr_q;
  assign reg_data_o    = reg_data_q;
  assign busy_o        = (state_q != S_IDLE);

  // New bytes enter at the MSB end and shift right, so after N bytes the
  // first byte received sits in bits [7:0].
  assign addr_next = {rx_data_i, addr_sr_q[ADDR_WIDTH-1:8]};
  assign data_next = {rx_data_i, data_sr_q[DATA_WIDTH-1:8]};

  always_comb begin
    state_d    = state_q;
    op_read_d  = op_read_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    tx_sr_d    = tx_sr_q;
    tx_left_d  = tx_left_q;

    case (state_q)
      S_IDLE: begin
        if (rx_accept) begin
          byte_cnt_d = '0;
          tmo_cnt_d  = '0;
          if (rx_data_i == OP_WRITE) begin
            op_read_d = 1'b0;
            state_d   = S_ADDR;
          end else if (rx_data_i == OP_READ) begin
            op_read_d = 1'b1;
            state_d   = S_ADDR;
          end else begin
            tx_sr_d   = RESP_W'(RESP_ERR);
            tx_left_d = ONE_BYTE;
            state_d   = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (rx_accept) begin
          addr_sr_d = addr_next;
          tmo_cnt_d = '0;
          if (byte_cnt_q == ADDR_LAST) begin
            byte_cnt_d = '0;
            if (op_read_q) begin
              // Address goes onto the bus as RWAIT is entered.
              reg_addr_d = addr_next;
              lat_cnt_d  = '0;
              state_d    = S_RWAIT;
            end else begin
              state_d = S_WDATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + ONE_BYTE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_WDATA: begin
        if (rx_accept) begin
          data_sr_d = data_next;
          tmo_cnt_d = '0;
          if (byte_cnt_q == DATA_LAST) begin
            byte_cnt_d = '0;
            reg_addr_d = addr_sr_q;
            reg_data_d = data_next;
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + ONE_BYTE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_WRITE: begin
        tx_sr_d   = RESP_W'(OP_WRITE);
        tx_left_d = ONE_BYTE;
        state_d   = S_RESP;
      end

      S_RWAIT: begin
        // RWAIT lasts READ_LATENCY cycles; the sample edge is the one that
        // leaves it, READ_LATENCY edges after the address was driven.
        if (lat_cnt_q == LAT_LAST) begin
          tx_sr_d   = {reg_data_i, OP_READ};
          tx_left_d = RD_RESP_LEN;
          state_d   = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (tx_fire) begin
          tx_sr_d   = tx_sr_q >> 8;
          tx_left_d = tx_left_q - ONE_BYTE;
          if (tx_left_q == ONE_BYTE) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      op_read_q  <= 1'b0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      addr_sr_q  <= '0;
      data_sr_q  <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      tx_sr_q    <= '0;
      tx_left_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_read_q  <= op_read_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      tx_sr_q    <= tx_sr_d;
      tx_left_q  <= tx_left_d;
    end
  end

endmodule

// File: tb/tb_host_reg_master.sv
// Directed bench for host_reg_master (TIMEOUT=16, READ_LATENCY=2).
// Inputs change 1ns after the rising edge; outputs are sampled there or on
// the falling edge by the monitor.
module tb_host_reg_master;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [15:0] reg_addr_o;
  logic [31:0] reg_data_o;
  logic        reg_data_oe_o;
  logic [31:0] reg_data_i;
  logic        reg_wr_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int          wr_cnt  = 0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          oe_viol = 0;
  logic [31:0] rd_pipe = '0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  host_reg_master #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (32),
    .READ_LATENCY(2),
    .TIMEOUT     (16)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .reg_addr_o   (reg_addr_o),
    .reg_data_o   (reg_data_o),
    .reg_data_oe_o(reg_data_oe_o),
    .reg_data_i   (reg_data_i),
    .reg_wr_o     (reg_wr_o),
    .busy_o       (busy_o)
  );

  // Register slave model: read data is registered from the address, so it
  // becomes valid one edge after the address changes.
  function automatic logic [31:0] lookup(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : 32'h0BAD0BAD;
  endfunction

  always @(posedge clk_i) rd_pipe <= lookup(reg_addr_o);
  assign reg_data_i = rd_pipe;

  // Monitor: record tx handshakes and write strobes.
  always @(negedge clk_i) begin
    if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
    if (reg_wr_o) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = reg_addr_o;
      wr_data = reg_data_o;
    end
    if (reg_data_oe_o && !reg_wr_o) oe_viol = oe_viol + 1;
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 40) begin
      tick();
      n++;
    end
    check("rx_ready_wait", 40'(rx_ready_o), 40'd1);
    tick();
    rx_valid_i = 1'b0;
  endtask

  // Scoreboard drain: wait for IDLE, then compare every captured byte.
  task automatic drain(input string tag);
    int n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 40'(busy_o), 40'd0);
    check({tag, "_len"}, 40'(got_q.size()), 40'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, 40'(got_q.pop_front()), 40'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 40'(rx_ready_o),    40'd0);
    check({tag, "_tx_valid"}, 40'(tx_valid_o),    40'd0);
    check({tag, "_wr"},       40'(reg_wr_o),      40'd0);
    check({tag, "_oe"},       40'(reg_data_oe_o), 40'd0);
    check({tag, "_addr"},     40'(reg_addr_o),    40'd0);
    check({tag, "_data"},     40'(reg_data_o),    40'd0);
    check({tag, "_busy"},     40'(busy_o),        40'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset_i    = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;

    // Reset state.
    repeat (3) tick();
    check_reset_outputs("rst");
    reset_i = 1'b0;
    tick();
    check("rst_rx_ready_after", 40'(rx_ready_o), 40'd1);

    // Write 0x12345678 to 0x0010.
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    check("wr_no_early_strobe", 40'(wr_cnt), 40'd0);
    send_byte(8'h12);
    check("wr_strobe",    40'(reg_wr_o),      40'd1);
    check("wr_oe",        40'(reg_data_oe_o), 40'd1);
    check("wr_addr",      40'(reg_addr_o),    40'h0010);
    check("wr_data",      40'(reg_data_o),    40'h12345678);
    check("wr_tx_idle",   40'(tx_valid_o),    40'd0);
    tick();
    check("wr_strobe_off", 40'(reg_wr_o),     40'd0);
    check("wr_tx_valid",   40'(tx_valid_o),   40'd1);
    exp_q.push_back(8'h01);
    drain("wr_resp");
    check("wr_count1", 40'(wr_cnt),  40'd1);
    check("wr_mon_addr", 40'(wr_addr), 40'h0010);
    check("wr_mon_data", 40'(wr_data), 40'h12345678);

    // Read 0x0010 -> DEADBEEF with continuous tx_ready.
    exp_q.push_back(8'h02); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h00);
    check("rd_addr",      40'(reg_addr_o),    40'h0010);
    check("rd_oe",        40'(reg_data_oe_o), 40'd0);
    check("rd_wait0",     40'(tx_valid_o),    40'd0);
    check("rd_rx_ready",  40'(rx_ready_o),    40'd0);
    tick();
    check("rd_wait1",     40'(tx_valid_o),    40'd0);
    tick();
    check("rd_tx_rise",   40'(tx_valid_o),    40'd1);
    repeat (5) tick();
    check("rd_throughput_idle", 40'(busy_o), 40'd0);
    drain("rd_resp");
    check("rd_no_write", 40'(wr_cnt), 40'd1);

    // Read 0x0020 with backpressure before and in the middle of the response.
    tx_ready_i = 1'b0;
    exp_q.push_back(8'h02); exp_q.push_back(8'hAD); exp_q.push_back(8'h0B);
    exp_q.push_back(8'hAD); exp_q.push_back(8'h0B);
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h00);
    n = 0;
    while (!tx_valid_o && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid", 40'(tx_valid_o), 40'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid0", 40'(tx_valid_o), 40'd1);
      check("bp_hold_data0",  40'(tx_data_o),  40'h02);
      tick();
    end
    tx_ready_i = 1'b1;
    tick();
    tick();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid2", 40'(tx_valid_o), 40'd1);
      check("bp_hold_data2",  40'(tx_data_o),  40'h0B);
      tick();
    end
    tx_ready_i = 1'b1;
    drain("bp_resp");

    // Bad opcode, then a normal write right after.
    send_byte(8'h7F);
    exp_q.push_back(8'hEE);
    drain("bad_resp");
    check("bad_no_write", 40'(wr_cnt), 40'd1);
    check("bad_addr_hold", 40'(reg_addr_o), 40'h0020);
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    exp_q.push_back(8'h01);
    drain("wr2_resp");
    check("wr2_count",   40'(wr_cnt),  40'd2);
    check("wr2_mon_addr", 40'(wr_addr), 40'h0020);
    check("wr2_mon_data", 40'(wr_data), 40'h11223344);

    // Timeout after two frame bytes: aborts on the 16th idle cycle.
    send_byte(8'h01); send_byte(8'h10);
    repeat (15) tick();
    check("tmo_still_busy", 40'(busy_o), 40'd1);
    tick();
    check("tmo_idle",     40'(busy_o),     40'd0);
    check("tmo_rx_ready", 40'(rx_ready_o), 40'd1);
    repeat (4) tick();
    check("tmo_no_write", 40'(wr_cnt),       40'd2);
    check("tmo_no_tx",    40'(got_q.size()), 40'd0);
    exp_q.push_back(8'h02); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h00);
    drain("tmo_rd_resp");

    // Reset after the 5th byte of a write frame.
    send_byte(8'h01); send_byte(8'h30); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    reset_i = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    reset_i = 1'b0;
    tick();
    check("mid_rst_rx_ready", 40'(rx_ready_o), 40'd1);
    check("mid_rst_no_write", 40'(wr_cnt),     40'd2);
    check("mid_rst_no_tx",    40'(got_q.size()), 40'd0);

    // Whole-run invariant: the bus is only driven during the write strobe.
    check("oe_only_in_write", 40'(oe_viol), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
